// File: rtl/idft_pkg.sv
// Shared definitions for the 16-point inverse DFT: widths, twiddle table,
// controller states and the output round/saturate helper.
package idft_pkg;

  localparam int BIN_W    = 28;
  localparam int TW_FRAC  = 17;
  localparam int BIN_FRAC = 17;
  localparam int OUT_W    = 8;
  localparam int TW_W     = TW_FRAC + 2;  // +1.0 needs one bit above the fraction plus sign
  localparam int PROD_W   = 46;
  localparam int ACC_W    = 51;
  localparam int SHIFT    = BIN_FRAC + TW_FRAC + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic signed [TW_W-1:0] COS_Q17 [0:15] = '{
     19'sd131072,  19'sd121094,  19'sd92681,   19'sd50159,
     19'sd0,      -19'sd50159,  -19'sd92681,  -19'sd121094,
    -19'sd131072, -19'sd121094, -19'sd92681,  -19'sd50159,
     19'sd0,       19'sd50159,   19'sd92681,   19'sd121094
  };

  localparam logic signed [TW_W-1:0] SIN_Q17 [0:15] = '{
     19'sd0,       19'sd50159,   19'sd92681,   19'sd121094,
     19'sd131072,  19'sd121094,  19'sd92681,   19'sd50159,
     19'sd0,      -19'sd50159,  -19'sd92681,  -19'sd121094,
    -19'sd131072, -19'sd121094, -19'sd92681,  -19'sd50159
  };

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((64'sd1 <<< OUT_W) - 64'sd1);

  // Scale by 2^-SHIFT (includes the 1/16), round half up, clamp to unsigned OUT_W.
  function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + RND_HALF) >>> SHIFT;
    if (r[ACC_W-1])
      return '0;
    else if (r > SAT_MAX)
      return '1;
    else
      return r[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/twiddle_rom16.sv
// Combinational 16-entry twiddle lookup: e^(j*2*pi*idx/16) as signed Q17 cos/sin.
module twiddle_rom16
  import idft_pkg::*;
(
  input  logic [3:0]             idx,
  output logic signed [TW_W-1:0] cos_v,
  output logic signed [TW_W-1:0] sin_v
);

  assign cos_v = COS_Q17[idx];
  assign sin_v = SIN_Q17[idx];

endmodule

// File: rtl/idft16_serial.sv
// Serial 16-point inverse DFT: one shared complex MAC, 16 cycles per real
// output sample, samples delivered over a valid/ready stream.
module idft16_serial
  import idft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*BIN_W-1:0]   bins_re,
  input  logic [16*BIN_W-1:0]   bins_im,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_idx,
  output logic [OUT_W-1:0]      out_sample,
  output logic                  done
);

  state_t                    state;
  logic [3:0]                n;
  logic [3:0]                k;
  logic [16*BIN_W-1:0]       re_q;
  logic [16*BIN_W-1:0]       im_q;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   term;
  logic signed [BIN_W-1:0]   re_k;
  logic signed [BIN_W-1:0]   im_k;
  logic [3:0]                t_idx;
  logic signed [TW_W-1:0]    cos_v;
  logic signed [TW_W-1:0]    sin_v;
  logic signed [PROD_W-1:0]  p_re;
  logic signed [PROD_W-1:0]  p_im;

  assign re_k  = re_q[k*BIN_W +: BIN_W];
  assign im_k  = im_q[k*BIN_W +: BIN_W];
  assign t_idx = k * n;  // (k*n) mod 16

  twiddle_rom16 u_rom (
    .idx   (t_idx),
    .cos_v (cos_v),
    .sin_v (sin_v)
  );

  assign p_re     = PROD_W'(re_k) * PROD_W'(cos_v);
  assign p_im     = PROD_W'(im_k) * PROD_W'(sin_v);
  assign term     = ACC_W'(p_re) - ACC_W'(p_im);
  assign acc_next = (k == 4'd0) ? term : acc + term;

  // Output stream: a sample transfers on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready is low, out_idx/out_sample hold stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      n          <= '0;
      k          <= '0;
      re_q       <= '0;
      im_q       <= '0;
      acc        <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_sample <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            re_q  <= bins_re;
            im_q  <= bins_im;
            n     <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 4'd1;
          if (k == 4'd15) begin
            out_sample <= round_sat(acc_next);
            out_idx    <= n;
            out_valid  <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            n         <= n + 4'd1;
            if (n == 4'd15) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
